// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with one partial-product step per clock and a start/done handshake.
// Optional build macro MULT_SIGNED_SEL_EN adds an is_signed port that selects signed or unsigned operands.

module mux3 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d0;
        endcase
    end
endmodule

module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef MULT_SIGNED_SEL_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int N  = WIDTH + 1;
    localparam int AW = N + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [N-1:0]       q_q, q_d;
    logic               q1_q, q1_d;
    logic [N-1:0]       m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [1:0]         sel;
    logic [AW-1:0]      m_pos, m_neg, addend, a_sum;

`ifdef MULT_SIGNED_SEL_EN
    assign signed_op = is_signed;
`else
    assign signed_op = 1'b1;
`endif

    // A is one bit wider than M so that negating the most negative M stays representable.
    assign m_pos = {m_q[N-1], m_q};
    assign m_neg = -m_pos;
    assign sel   = {q_q[0] & ~q1_q, ~q_q[0] & q1_q};

    mux3 #(.WIDTH(AW)) u_addend_mux (
        .sel (sel),
        .d0  ('0),
        .d1  (m_pos),
        .d2  (m_neg),
        .y   (addend)
    );

    assign a_sum = a_q + addend;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = {signed_op & multiplier[WIDTH-1], multiplier};
                    q1_d    = 1'b0;
                    m_d     = {signed_op & multiplicand[WIDTH-1], multiplicand};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {a_sum[AW-1], a_sum[AW-1:1]};
                q_d   = {a_sum[0], q_q[N-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Low 2*WIDTH bits of {A,Q}: all of Q plus the bottom WIDTH-1 bits of A.
                    product_d = {a_d[WIDTH-2:0], q_d};
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule
